rs_scheduler: RTL and testbench
===============================

Name: rs_scheduler

Overview:
- Reservation station that buffers dispatched ALU/branch instructions until both operands are ready, then issues one per cycle to the execute unit.
- Snoops the two CDB producers (execute and store/load buffer) to wake up waiting operands.
- Sits between the dispatcher and execute; cleared by the ROB on a misprediction flush.

Parameters:
RS_SIZE, 16, number of entries (power of two, 2..32)
IDX_W, 4, log2(RS_SIZE)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
rdy  in  1  global enable; when 0 all state and outputs hold
iDP_en  in  1  dispatch valid
iDP_pc  in  32  instruction pc
iDP_op  in  6  internal opcode (OpBus)
iDP_imm  in  32  immediate
iDP_rd_nick  in  4  ROB tag of result (NickBus)
iDP_rs1_rdy / iDP_rs2_rdy  in  1 each  operand already valid
iDP_rs1_dt / iDP_rs2_dt  in  32 each  operand value when ready
iDP_rs1_nick / iDP_rs2_nick  in  4 each  producer tag when not ready
oRS_full  out  1  no free entry (combinational from valid vector)
iEX_en, iEX_nick, iEX_dt  in  1/4/32  execute CDB broadcast
iSLB_en, iSLB_nick, iSLB_dt  in  1/4/32  load/store buffer CDB broadcast
iROB_clear  in  1  flush all entries
oRS_en  out  1  issue valid to execute
oRS_pc, oRS_op, oRS_imm, oRS_rd_nick, oRS_rs1_dt, oRS_rs2_dt  out  32/6/32/4/32/32  issued instruction

Behaviour:
- Per entry: valid, pc, op, imm, rd_nick, and for rs1 and rs2 each a ready bit, a nick and a data word.
- Reset (rst=0, async): all valid=0. oRS_en=0. All oRS_* data outputs=0.
- rdy=0: no register changes. Dispatch, CDB and clear inputs are ignored that cycle.
- Dispatch: on iDP_en && !oRS_full, write the lowest-index free entry, selected from the valid vector at the start of the cycle.
  - iDP_en while oRS_full: the instruction is dropped with no state change. Dispatcher must not do this; the bench flags it.
- Dispatch bypass: if a not-ready dispatched operand's nick matches a same-cycle iEX or iSLB broadcast, the entry is written with ready=1 and the CDB data.
- Wakeup: each cycle, every valid entry operand with ready=0 and nick == iEX_nick (iEX_en=1) captures iEX_dt and sets ready.
  - Same check for iSLB.
  - If both broadcasts match the same operand, iEX wins (must not occur; no error raised).
- Select: candidate = valid && rs1 ready && rs2 ready, evaluated on registered state.
  - An operand woken in cycle N is issuable in cycle N+1.
  - Lowest-index candidate wins.
- Issue: on a winner, the next edge sets oRS_en=1, registers the entry fields to oRS_*, and clears that entry's valid.
  - No candidate: oRS_en=0 and data outputs hold their previous values.
  - Latency: dispatch with both operands ready at edge N gives oRS_en=1 after edge N+1.
- Dispatch and issue in the same cycle are both performed. The issued slot is not reusable until the next cycle.
- Flush: iROB_clear=1 at an edge clears all valid, sets oRS_en=0 and ignores same-cycle dispatch. Has priority over everything except reset.
- oRS_full = &valid. Entries are never partially overwritten; indices do not wrap.
- Ops with no rs2 (LUI, AUIPC, JAL, I-type): the dispatcher supplies rs2_rdy=1. The scheduler does not decode op.

Decomposition:
- Shared config package: bus widths (AddrBus, DataBus, ImmBus, OpBus, NickBus) and opcode constants. RS_SIZE default goes here too.
- Sub-module rs_prio_enc: parameterised lowest-index priority encoder (valid out, IDX_W index out).
  - Instantiated twice: free-slot select and ready-entry select.

Test Plan:
- Reset mid-traffic: 3 entries valid, drive rst=0 asynchronously -> oRS_en=0 immediately, oRS_full=0, no issue after release.
- Ready dispatch: ADDI pc=0x100, rs1_dt=5, imm=3, rd_nick=2, both ready at edge 0 -> oRS_en=1 after edge 1 with oRS_rs1_dt=5, oRS_imm=3, oRS_rd_nick=2. Execute returns 8.
- Wakeup: ADD rs1 waiting nick=7, rs2 ready=4. iSLB_en nick=7 dt=10 at edge 3 -> issue after edge 4 with rs1_dt=10.
- Dispatch bypass: dispatch rs1 nick=5 not ready while iEX_en nick=5 dt=0xFFFFFFFF in the same cycle -> entry ready, issues next cycle with rs1_dt=0xFFFFFFFF.
- Fill and priority: 16 dispatches all waiting on nick=1 -> oRS_full=1, 17th dropped. iEX nick=1 -> issues entries 0..15 in order on 16 consecutive cycles, oRS_full drops after the first issue.
- Flush: 4 entries pending plus a dispatch with iROB_clear=1 -> no oRS_en afterwards, oRS_full=0, and a fresh dispatch issues normally.

Source files
------------

// File: rtl/rs_scheduler_pkg.sv
// Shared bus widths, opcode constants and entry types for the reservation station.
package rs_scheduler_pkg;

   localparam int AddrBus     = 32;
   localparam int DataBus     = 32;
   localparam int ImmBus      = 32;
   localparam int OpBus       = 6;
   localparam int NickBus     = 4;
   localparam int RS_SIZE_DEF = 16;

   localparam logic [OpBus-1:0] OP_LUI   = 6'd0;
   localparam logic [OpBus-1:0] OP_AUIPC = 6'd1;
   localparam logic [OpBus-1:0] OP_JAL   = 6'd2;
   localparam logic [OpBus-1:0] OP_BEQ   = 6'd4;
   localparam logic [OpBus-1:0] OP_ADDI  = 6'd16;
   localparam logic [OpBus-1:0] OP_ADD   = 6'd32;
   localparam logic [OpBus-1:0] OP_SUB   = 6'd33;

   typedef struct packed {
      logic               rdy;
      logic [DataBus-1:0] dt;
   } opnd_t;

   typedef struct packed {
      logic               valid;
      logic [AddrBus-1:0] pc;
      logic [OpBus-1:0]   op;
      logic [ImmBus-1:0]  imm;
      logic [NickBus-1:0] rd_nick;
      logic [NickBus-1:0] rs1_nick;
      logic [NickBus-1:0] rs2_nick;
      opnd_t              rs1;
      opnd_t              rs2;
   } rs_entry_t;

   // A waiting operand grabs a matching CDB value; the execute bus wins a tie.
   function automatic opnd_t snoop_operand(
      input logic               rdy_in,
      input logic [NickBus-1:0] nick,
      input logic [DataBus-1:0] dt_in,
      input logic               ex_en,
      input logic [NickBus-1:0] ex_nick,
      input logic [DataBus-1:0] ex_dt,
      input logic               slb_en,
      input logic [NickBus-1:0] slb_nick,
      input logic [DataBus-1:0] slb_dt
   );
      opnd_t o;
      o.rdy = rdy_in;
      o.dt  = dt_in;
      if (!rdy_in) begin
         if (ex_en && (nick == ex_nick)) begin
            o.rdy = 1'b1;
            o.dt  = ex_dt;
         end else if (slb_en && (nick == slb_nick)) begin
            o.rdy = 1'b1;
            o.dt  = slb_dt;
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/rs_scheduler_prio_enc.sv
// Lowest-index priority encoder: reports whether any request is set and which one wins.
module rs_prio_enc #(
   parameter int N     = 16,
   parameter int IDX_W = 4
) (
   input  logic [N-1:0]     req,
   output logic             vld,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      vld = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            vld = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/rs_scheduler.sv
// Reservation station: holds dispatched ALU/branch ops, wakes operands from both CDBs,
// and issues the lowest-index ready entry each cycle.
module rs_scheduler
   import rs_scheduler_pkg::*;
#(
   parameter int RS_SIZE = RS_SIZE_DEF,
   parameter int IDX_W   = $clog2(RS_SIZE)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               iDP_en,
   input  logic [AddrBus-1:0] iDP_pc,
   input  logic [OpBus-1:0]   iDP_op,
   input  logic [ImmBus-1:0]  iDP_imm,
   input  logic [NickBus-1:0] iDP_rd_nick,
   input  logic               iDP_rs1_rdy,
   input  logic               iDP_rs2_rdy,
   input  logic [DataBus-1:0] iDP_rs1_dt,
   input  logic [DataBus-1:0] iDP_rs2_dt,
   input  logic [NickBus-1:0] iDP_rs1_nick,
   input  logic [NickBus-1:0] iDP_rs2_nick,
   output logic               oRS_full,
   input  logic               iEX_en,
   input  logic [NickBus-1:0] iEX_nick,
   input  logic [DataBus-1:0] iEX_dt,
   input  logic               iSLB_en,
   input  logic [NickBus-1:0] iSLB_nick,
   input  logic [DataBus-1:0] iSLB_dt,
   input  logic               iROB_clear,
   output logic               oRS_en,
   output logic [AddrBus-1:0] oRS_pc,
   output logic [OpBus-1:0]   oRS_op,
   output logic [ImmBus-1:0]  oRS_imm,
   output logic [NickBus-1:0] oRS_rd_nick,
   output logic [DataBus-1:0] oRS_rs1_dt,
   output logic [DataBus-1:0] oRS_rs2_dt
);

   rs_entry_t ent_q [RS_SIZE];
   rs_entry_t ent_d [RS_SIZE];
   rs_entry_t disp_ent;

   logic [RS_SIZE-1:0] valid_vec;
   logic [RS_SIZE-1:0] cand_vec;
   logic               free_vld;
   logic               sel_vld;
   logic [IDX_W-1:0]   free_idx;
   logic [IDX_W-1:0]   sel_idx;

   logic               en_q, en_d;
   logic [AddrBus-1:0] pc_q, pc_d;
   logic [OpBus-1:0]   op_q, op_d;
   logic [ImmBus-1:0]  imm_q, imm_d;
   logic [NickBus-1:0] rd_nick_q, rd_nick_d;
   logic [DataBus-1:0] rs1_dt_q, rs1_dt_d;
   logic [DataBus-1:0] rs2_dt_q, rs2_dt_d;

   always_comb begin
      valid_vec = '0;
      cand_vec  = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         valid_vec[i] = ent_q[i].valid;
         cand_vec[i]  = ent_q[i].valid & ent_q[i].rs1.rdy & ent_q[i].rs2.rdy;
      end
   end

   assign oRS_full = &valid_vec;

   rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
      .req (~valid_vec),
      .vld (free_vld),
      .idx (free_idx)
   );

   rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_sel_enc (
      .req (cand_vec),
      .vld (sel_vld),
      .idx (sel_idx)
   );

   // Incoming entry, with operands already resolved against this cycle's broadcasts.
   always_comb begin
      disp_ent          = '0;
      disp_ent.valid    = 1'b1;
      disp_ent.pc       = iDP_pc;
      disp_ent.op       = iDP_op;
      disp_ent.imm      = iDP_imm;
      disp_ent.rd_nick  = iDP_rd_nick;
      disp_ent.rs1_nick = iDP_rs1_nick;
      disp_ent.rs2_nick = iDP_rs2_nick;
      disp_ent.rs1      = snoop_operand(iDP_rs1_rdy, iDP_rs1_nick, iDP_rs1_dt,
                                        iEX_en, iEX_nick, iEX_dt,
                                        iSLB_en, iSLB_nick, iSLB_dt);
      disp_ent.rs2      = snoop_operand(iDP_rs2_rdy, iDP_rs2_nick, iDP_rs2_dt,
                                        iEX_en, iEX_nick, iEX_dt,
                                        iSLB_en, iSLB_nick, iSLB_dt);
   end

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         ent_d[i] = ent_q[i];
      end
      en_d      = en_q;
      pc_d      = pc_q;
      op_d      = op_q;
      imm_d     = imm_q;
      rd_nick_d = rd_nick_q;
      rs1_dt_d  = rs1_dt_q;
      rs2_dt_d  = rs2_dt_q;

      if (rdy) begin
         en_d = 1'b0;
         if (iROB_clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
               ent_d[i].valid = 1'b0;
            end
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (ent_q[i].valid) begin
                  ent_d[i].rs1 = snoop_operand(ent_q[i].rs1.rdy, ent_q[i].rs1_nick, ent_q[i].rs1.dt,
                                               iEX_en, iEX_nick, iEX_dt,
                                               iSLB_en, iSLB_nick, iSLB_dt);
                  ent_d[i].rs2 = snoop_operand(ent_q[i].rs2.rdy, ent_q[i].rs2_nick, ent_q[i].rs2.dt,
                                               iEX_en, iEX_nick, iEX_dt,
                                               iSLB_en, iSLB_nick, iSLB_dt);
               end
            end

            if (sel_vld) begin
               en_d                  = 1'b1;
               pc_d                  = ent_q[sel_idx].pc;
               op_d                  = ent_q[sel_idx].op;
               imm_d                 = ent_q[sel_idx].imm;
               rd_nick_d             = ent_q[sel_idx].rd_nick;
               rs1_dt_d              = ent_q[sel_idx].rs1.dt;
               rs2_dt_d              = ent_q[sel_idx].rs2.dt;
               ent_d[sel_idx].valid  = 1'b0;
            end

            // The free slot comes from the start-of-cycle valid vector, so it never
            // collides with the entry being issued.
            if (iDP_en && free_vld) begin
               ent_d[free_idx] = disp_ent;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            ent_q[i] <= '0;
         end
         en_q      <= 1'b0;
         pc_q      <= '0;
         op_q      <= '0;
         imm_q     <= '0;
         rd_nick_q <= '0;
         rs1_dt_q  <= '0;
         rs2_dt_q  <= '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            ent_q[i] <= ent_d[i];
         end
         en_q      <= en_d;
         pc_q      <= pc_d;
         op_q      <= op_d;
         imm_q     <= imm_d;
         rd_nick_q <= rd_nick_d;
         rs1_dt_q  <= rs1_dt_d;
         rs2_dt_q  <= rs2_dt_d;
      end
   end

   assign oRS_en      = en_q;
   assign oRS_pc      = pc_q;
   assign oRS_op      = op_q;
   assign oRS_imm     = imm_q;
   assign oRS_rd_nick = rd_nick_q;
   assign oRS_rs1_dt  = rs1_dt_q;
   assign oRS_rs2_dt  = rs2_dt_q;

endmodule

// File: tb/tb_rs_scheduler.sv
// Self-checking bench for rs_scheduler: table vectors, directed corner sequences and
// random traffic against a slot-array reference model.
module tb_rs_scheduler;
   import rs_scheduler_pkg::*;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        iDP_en;
   logic [31:0] iDP_pc;
   logic [5:0]  iDP_op;
   logic [31:0] iDP_imm;
   logic [3:0]  iDP_rd_nick;
   logic        iDP_rs1_rdy, iDP_rs2_rdy;
   logic [31:0] iDP_rs1_dt, iDP_rs2_dt;
   logic [3:0]  iDP_rs1_nick, iDP_rs2_nick;
   logic        oRS_full;
   logic        iEX_en;
   logic [3:0]  iEX_nick;
   logic [31:0] iEX_dt;
   logic        iSLB_en;
   logic [3:0]  iSLB_nick;
   logic [31:0] iSLB_dt;
   logic        iROB_clear;
   logic        oRS_en;
   logic [31:0] oRS_pc, oRS_imm, oRS_rs1_dt, oRS_rs2_dt;
   logic [5:0]  oRS_op;
   logic [3:0]  oRS_rd_nick;

   int total = 0;
   int bad   = 0;

   rs_scheduler dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .iDP_en(iDP_en), .iDP_pc(iDP_pc), .iDP_op(iDP_op), .iDP_imm(iDP_imm),
      .iDP_rd_nick(iDP_rd_nick), .iDP_rs1_rdy(iDP_rs1_rdy), .iDP_rs2_rdy(iDP_rs2_rdy),
      .iDP_rs1_dt(iDP_rs1_dt), .iDP_rs2_dt(iDP_rs2_dt),
      .iDP_rs1_nick(iDP_rs1_nick), .iDP_rs2_nick(iDP_rs2_nick),
      .oRS_full(oRS_full),
      .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
      .iSLB_en(iSLB_en), .iSLB_nick(iSLB_nick), .iSLB_dt(iSLB_dt),
      .iROB_clear(iROB_clear),
      .oRS_en(oRS_en), .oRS_pc(oRS_pc), .oRS_op(oRS_op), .oRS_imm(oRS_imm),
      .oRS_rd_nick(oRS_rd_nick), .oRS_rs1_dt(oRS_rs1_dt), .oRS_rs2_dt(oRS_rs2_dt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a plain array of slots plus the expected output registers.
   typedef struct {
      bit          v;
      logic [31:0] pc;
      logic [5:0]  op;
      logic [31:0] imm;
      logic [3:0]  rd;
      bit          r1;
      logic [3:0]  n1;
      logic [31:0] d1;
      bit          r2;
      logic [3:0]  n2;
      logic [31:0] d2;
   } mslot_t;

   mslot_t      m [16];
   bit          e_en;
   logic [31:0] e_pc, e_imm, e_d1, e_d2;
   logic [5:0]  e_op;
   logic [3:0]  e_rd;

   typedef struct {
      logic [31:0] pc;  logic [5:0] op; logic [31:0] imm; logic [3:0] rd;
      logic r1; logic [3:0] n1; logic [31:0] d1;
      logic r2; logic [3:0] n2; logic [31:0] d2;
      logic ex_en; logic [3:0] ex_n; logic [31:0] ex_d;
      logic sl_en; logic [3:0] sl_n; logic [31:0] sl_d;
      logic x_en; logic [31:0] x_d1; logic [31:0] x_d2;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_full();
      for (int i = 0; i < 16; i++) if (!m[i].v) return 1'b0;
      return 1'b1;
   endfunction

   function automatic mslot_t wake_slot(input mslot_t s);
      mslot_t o = s;
      if (!o.r1) begin
         if (iEX_en && o.n1 == iEX_nick) begin o.r1 = 1; o.d1 = iEX_dt; end
         else if (iSLB_en && o.n1 == iSLB_nick) begin o.r1 = 1; o.d1 = iSLB_dt; end
      end
      if (!o.r2) begin
         if (iEX_en && o.n2 == iEX_nick) begin o.r2 = 1; o.d2 = iEX_dt; end
         else if (iSLB_en && o.n2 == iSLB_nick) begin o.r2 = 1; o.d2 = iSLB_dt; end
      end
      return o;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m[i].v = 0;
      e_en = 0; e_pc = 0; e_op = 0; e_imm = 0; e_rd = 0; e_d1 = 0; e_d2 = 0;
   endtask

   task automatic model_step();
      mslot_t nm [16];
      mslot_t s;
      int win = -1;
      int fr  = -1;
      bit full;
      if (!rdy) return;
      if (iROB_clear) begin
         for (int i = 0; i < 16; i++) m[i].v = 0;
         e_en = 0;
         return;
      end
      full = m_full();
      for (int i = 0; i < 16; i++) begin
         if (win < 0 && m[i].v && m[i].r1 && m[i].r2) win = i;
         if (fr < 0 && !m[i].v) fr = i;
         nm[i] = m[i].v ? wake_slot(m[i]) : m[i];
      end
      e_en = (win >= 0);
      if (win >= 0) begin
         e_pc = m[win].pc; e_op = m[win].op; e_imm = m[win].imm; e_rd = m[win].rd;
         e_d1 = m[win].d1; e_d2 = m[win].d2;
         nm[win].v = 0;
      end
      if (iDP_en && !full) begin
         s.v = 1; s.pc = iDP_pc; s.op = iDP_op; s.imm = iDP_imm; s.rd = iDP_rd_nick;
         s.r1 = iDP_rs1_rdy; s.n1 = iDP_rs1_nick; s.d1 = iDP_rs1_dt;
         s.r2 = iDP_rs2_rdy; s.n2 = iDP_rs2_nick; s.d2 = iDP_rs2_dt;
         nm[fr] = wake_slot(s);
      end else if (iDP_en) begin
         $display("note: dispatch while oRS_full is dropped (pc=%h)", iDP_pc);
      end
      for (int i = 0; i < 16; i++) m[i] = nm[i];
   endtask

   task automatic drive_idle();
      rdy = 1; iDP_en = 0; iDP_pc = 0; iDP_op = 0; iDP_imm = 0; iDP_rd_nick = 0;
      iDP_rs1_rdy = 0; iDP_rs2_rdy = 0; iDP_rs1_dt = 0; iDP_rs2_dt = 0;
      iDP_rs1_nick = 0; iDP_rs2_nick = 0;
      iEX_en = 0; iEX_nick = 0; iEX_dt = 0; iSLB_en = 0; iSLB_nick = 0; iSLB_dt = 0;
      iROB_clear = 0;
   endtask

   task automatic dispatch(input logic [31:0] pc, input logic [5:0] op, input logic [31:0] imm,
                           input logic [3:0] rd, input logic r1, input logic [3:0] n1,
                           input logic [31:0] d1, input logic r2, input logic [3:0] n2,
                           input logic [31:0] d2);
      iDP_en = 1; iDP_pc = pc; iDP_op = op; iDP_imm = imm; iDP_rd_nick = rd;
      iDP_rs1_rdy = r1; iDP_rs1_nick = n1; iDP_rs1_dt = d1;
      iDP_rs2_rdy = r2; iDP_rs2_nick = n2; iDP_rs2_dt = d2;
   endtask

   // One clock: inputs are already driven at the falling edge; outputs checked #1 after rise.
   task automatic cycle();
      chk("m_full", {31'd0, oRS_full}, {31'd0, m_full()});
      model_step();
      @(posedge clk);
      #1;
      chk("m_en", {31'd0, oRS_en}, {31'd0, e_en});
      chk("m_pc", oRS_pc, e_pc);
      chk("m_op", {26'd0, oRS_op}, {26'd0, e_op});
      chk("m_imm", oRS_imm, e_imm);
      chk("m_rd", {28'd0, oRS_rd_nick}, {28'd0, e_rd});
      chk("m_rs1", oRS_rs1_dt, e_d1);
      chk("m_rs2", oRS_rs2_dt, e_d2);
      @(negedge clk);
      drive_idle();
   endtask

   initial begin
      tbl[0] = '{32'h100, OP_ADDI, 32'd3, 4'd2, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd0,
                 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'd5, 32'd0};
      tbl[1] = '{32'h104, OP_ADD, 32'd0, 4'd1, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'd7,
                 1'b1, 4'd5, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd7};
      tbl[2] = '{32'h108, OP_SUB, 32'd0, 4'd3, 1'b1, 4'd0, 32'd1, 1'b0, 4'd6, 32'd0,
                 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h1234, 1'b1, 32'd1, 32'h1234};
      tbl[3] = '{32'h10C, OP_ADD, 32'd0, 4'd4, 1'b0, 4'd3, 32'd0, 1'b0, 4'd4, 32'd0,
                 1'b1, 4'd3, 32'hA, 1'b1, 4'd4, 32'hB, 1'b1, 32'hA, 32'hB};
      tbl[4] = '{32'h110, OP_BEQ, 32'hFFFF_FFF8, 4'd5, 1'b0, 4'd2, 32'd0, 1'b0, 4'd2, 32'd0,
                 1'b1, 4'd2, 32'h55, 1'b0, 4'd0, 32'd0, 1'b1, 32'h55, 32'h55};
      tbl[5] = '{32'h114, OP_ADD, 32'd0, 4'd6, 1'b0, 4'd8, 32'd0, 1'b1, 4'd0, 32'd9,
                 1'b1, 4'd9, 32'h77, 1'b1, 4'd7, 32'h66, 1'b0, 32'd0, 32'd0};
      tbl[6] = '{32'h118, OP_ADDI, 32'd16, 4'd7, 1'b0, 4'd3, 32'd0, 1'b1, 4'd0, 32'd0,
                 1'b1, 4'd3, 32'h11, 1'b1, 4'd3, 32'h22, 1'b1, 32'h11, 32'd0};
      tbl[7] = '{32'h11C, OP_LUI, 32'h1234_5000, 4'd8, 1'b1, 4'd0, 32'd0, 1'b0, 4'hF, 32'd0,
                 1'b0, 4'd0, 32'd0, 1'b1, 4'hF, 32'hDEAD, 1'b1, 32'd0, 32'hDEAD};

      drive_idle();
      rst = 0;
      model_reset();
      #12;
      chk("rst_en", {31'd0, oRS_en}, 32'd0);
      chk("rst_full", {31'd0, oRS_full}, 32'd0);
      chk("rst_pc", oRS_pc, 32'd0);
      chk("rst_rs1", oRS_rs1_dt, 32'd0);
      @(negedge clk);
      rst = 1;

      // Table vectors: dispatch (plus same-cycle CDB), then look one edge later.
      for (int k = 0; k < 8; k++) begin
         dispatch(tbl[k].pc, tbl[k].op, tbl[k].imm, tbl[k].rd, tbl[k].r1, tbl[k].n1, tbl[k].d1,
                  tbl[k].r2, tbl[k].n2, tbl[k].d2);
         iEX_en = tbl[k].ex_en; iEX_nick = tbl[k].ex_n; iEX_dt = tbl[k].ex_d;
         iSLB_en = tbl[k].sl_en; iSLB_nick = tbl[k].sl_n; iSLB_dt = tbl[k].sl_d;
         cycle();
         chk("tbl_en_early", {31'd0, oRS_en}, 32'd0);
         cycle();
         chk("tbl_en", {31'd0, oRS_en}, {31'd0, tbl[k].x_en});
         if (tbl[k].x_en) begin
            chk("tbl_pc", oRS_pc, tbl[k].pc);
            chk("tbl_imm", oRS_imm, tbl[k].imm);
            chk("tbl_rd", {28'd0, oRS_rd_nick}, {28'd0, tbl[k].rd});
            chk("tbl_rs1", oRS_rs1_dt, tbl[k].x_d1);
            chk("tbl_rs2", oRS_rs2_dt, tbl[k].x_d2);
         end else begin
            iROB_clear = 1;
            cycle();
         end
      end

      // Wakeup from the load/store CDB: issuable the cycle after the broadcast.
      dispatch(32'h200, OP_ADD, 32'd0, 4'd9, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd4);
      cycle();
      cycle();
      chk("wk_wait", {31'd0, oRS_en}, 32'd0);
      iSLB_en = 1; iSLB_nick = 4'd7; iSLB_dt = 32'd10;
      cycle();
      chk("wk_same", {31'd0, oRS_en}, 32'd0);
      cycle();
      chk("wk_en", {31'd0, oRS_en}, 32'd1);
      chk("wk_rs1", oRS_rs1_dt, 32'd10);
      chk("wk_rs2", oRS_rs2_dt, 32'd4);

      // rdy=0 ignores a dispatch entirely.
      rdy = 0;
      dispatch(32'h240, OP_ADDI, 32'd1, 4'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd0);
      cycle();
      cycle();
      chk("rdy0_en", {31'd0, oRS_en}, 32'd0);
      chk("rdy0_full", {31'd0, oRS_full}, 32'd0);

      // Fill, drop the 17th, then drain in index order.
      for (int k = 0; k < 16; k++) begin
         dispatch(32'h1000 + 32'(4 * k), OP_ADD, 32'd0, 4'(k), 1'b0, 4'd1, 32'd0,
                  1'b1, 4'd0, 32'(k));
         cycle();
      end
      chk("fill_full", {31'd0, oRS_full}, 32'd1);
      dispatch(32'hBAD0, OP_ADD, 32'd0, 4'd0, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
      cycle();
      chk("fill_drop_en", {31'd0, oRS_en}, 32'd0);
      iEX_en = 1; iEX_nick = 4'd1; iEX_dt = 32'h77;
      cycle();
      chk("fill_wake_en", {31'd0, oRS_en}, 32'd0);
      for (int k = 0; k < 16; k++) begin
         cycle();
         chk("drain_en", {31'd0, oRS_en}, 32'd1);
         chk("drain_pc", oRS_pc, 32'h1000 + 32'(4 * k));
         if (k == 0) chk("drain_full", {31'd0, oRS_full}, 32'd0);
      end
      cycle();
      chk("drain_done", {31'd0, oRS_en}, 32'd0);

      // Flush with pending entries and a colliding dispatch.
      for (int k = 0; k < 4; k++) begin
         dispatch(32'h2000 + 32'(4 * k), OP_ADD, 32'd0, 4'd2, 1'b0, 4'd3, 32'd0,
                  1'b1, 4'd0, 32'd0);
         cycle();
      end
      dispatch(32'h2100, OP_ADDI, 32'd0, 4'd2, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
      iROB_clear = 1;
      cycle();
      chk("fl_en", {31'd0, oRS_en}, 32'd0);
      chk("fl_full", {31'd0, oRS_full}, 32'd0);
      iEX_en = 1; iEX_nick = 4'd3; iEX_dt = 32'h5;
      cycle();
      cycle();
      chk("fl_quiet", {31'd0, oRS_en}, 32'd0);
      dispatch(32'h300, OP_ADDI, 32'd8, 4'd4, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'd0);
      cycle();
      cycle();
      chk("fl_fresh_en", {31'd0, oRS_en}, 32'd1);
      chk("fl_fresh_pc", oRS_pc, 32'h300);

      // Asynchronous reset while entries are pending and one is issuing.
      for (int k = 0; k < 4; k++) begin
         dispatch(32'h400 + 32'(4 * k), OP_ADD, 32'd0, 4'd1, 1'b0, 4'd9, 32'd0,
                  1'b1, 4'd0, 32'd0);
         cycle();
      end
      iEX_en = 1; iEX_nick = 4'd9; iEX_dt = 32'h9;
      cycle();
      cycle();
      chk("ar_pre_en", {31'd0, oRS_en}, 32'd1);
      #2;
      rst = 0;
      #1;
      model_reset();
      chk("ar_en", {31'd0, oRS_en}, 32'd0);
      chk("ar_full", {31'd0, oRS_full}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1;
      drive_idle();
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("ar_after", {31'd0, oRS_en}, 32'd0);
      end

      // Random traffic against the model.
      for (int n = 0; n < 800; n++) begin
         rdy = ($urandom_range(0, 9) != 0);
         iROB_clear = ($urandom_range(0, 39) == 0);
         if (!m_full() && $urandom_range(0, 1) == 1) begin
            dispatch($urandom, 6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom,
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom);
         end
         iEX_en = ($urandom_range(0, 2) == 0);
         iEX_nick = 4'($urandom_range(0, 3));
         iEX_dt = $urandom;
         iSLB_en = ($urandom_range(0, 2) == 0);
         iSLB_nick = 4'($urandom_range(0, 3));
         iSLB_dt = $urandom;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
